// File: rtl/layer_result_pingpong_buf.sv
// rtl/layer_result_pingpong_buf.sv - double-buffered feature-map store between two CNN layers
// Producer fills one bank by (row, col) while the consumer drains the other; banks swap on frame-done.
module layer_result_pingpong_buf #(
   parameter int DATA_W = 128,
   parameter int MAP_W  = 30,
   parameter int MAP_H  = 30,
   parameter int IDX_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_row,
   input  logic [IDX_W-1:0]  wr_col,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_frame_done,
   output logic              wr_ready,
   input  logic              rd_en,
   input  logic [IDX_W-1:0]  rd_row,
   input  logic [IDX_W-1:0]  rd_col,
   input  logic              rd_frame_done,
   output logic              rd_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              wr_bank,
   output logic              rd_bank,
   output logic              addr_err,
   input  logic              err_clr
);

   localparam int DEPTH = MAP_W * MAP_H;
   localparam int AW    = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [2][DEPTH];
   logic [1:0]        full;
   logic [1:0]        full_nxt;
   logic [AW-1:0]     wr_addr;
   logic [AW-1:0]     rd_addr;
   logic              wr_inr;
   logic              rd_inr;
   logic              wr_acc;
   logic              rd_acc;
   logic              wr_close;
   logic              rd_release;
   logic              err_set;

   assign wr_ready = ~full[wr_bank];
   assign rd_ready = full[rd_bank];

   // Range is judged on the untruncated indices so wrapped addresses never alias.
   assign wr_inr  = (wr_row < IDX_W'(MAP_H)) && (wr_col < IDX_W'(MAP_W));
   assign rd_inr  = (rd_row < IDX_W'(MAP_H)) && (rd_col < IDX_W'(MAP_W));
   assign wr_addr = AW'(32'(wr_row) * MAP_W + 32'(wr_col));
   assign rd_addr = AW'(32'(rd_row) * MAP_W + 32'(rd_col));

   assign wr_acc     = wr_en & wr_ready & wr_inr;
   assign rd_acc     = rd_en & rd_ready & rd_inr;
   assign wr_close   = wr_frame_done & wr_ready;
   assign rd_release = rd_frame_done & rd_ready;
   assign err_set    = (wr_en & wr_ready & ~wr_inr) | (rd_en & rd_ready & ~rd_inr);

   // Fill bank is never full and drain bank always is, so the two updates never touch the same bit.
   always_comb begin
      full_nxt = full;
      if (wr_close) full_nxt[wr_bank] = 1'b1;
      if (rd_release) full_nxt[rd_bank] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_bank][wr_addr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         full     <= 2'b00;
         wr_bank  <= 1'b0;
         rd_bank  <= 1'b0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
         addr_err <= 1'b0;
      end else begin
         full     <= full_nxt;
         wr_bank  <= wr_bank ^ wr_close;
         rd_bank  <= rd_bank ^ rd_release;
         rd_valid <= rd_acc;
         rd_data  <= rd_acc ? mem[rd_bank][rd_addr] : '0;
         addr_err <= err_set | (addr_err & ~err_clr);
      end
   end

endmodule

// File: tb/tb_layer_result_pingpong_buf.sv
// tb/tb_layer_result_pingpong_buf.sv - scoreboard bench for layer_result_pingpong_buf
// Reads push expected words into a queue; a negedge monitor pops and compares on rd_valid.
module tb_layer_result_pingpong_buf;

   localparam int DATA_W = 128;
   localparam int IDX_W  = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              wr_en = 1'b0;
   logic [IDX_W-1:0]  wr_row = '0;
   logic [IDX_W-1:0]  wr_col = '0;
   logic [DATA_W-1:0] wr_data = '0;
   logic              wr_frame_done = 1'b0;
   logic              wr_ready;
   logic              rd_en = 1'b0;
   logic [IDX_W-1:0]  rd_row = '0;
   logic [IDX_W-1:0]  rd_col = '0;
   logic              rd_frame_done = 1'b0;
   logic              rd_ready;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              wr_bank;
   logic              rd_bank;
   logic              addr_err;
   logic              err_clr = 1'b0;

   int checks = 0;
   int errors = 0;
   logic [DATA_W-1:0] exp_q[$];

   layer_result_pingpong_buf dut (
      .clk(clk), .rst(rst),
      .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
      .wr_frame_done(wr_frame_done), .wr_ready(wr_ready),
      .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col),
      .rd_frame_done(rd_frame_done), .rd_ready(rd_ready),
      .rd_data(rd_data), .rd_valid(rd_valid),
      .wr_bank(wr_bank), .rd_bank(rd_bank),
      .addr_err(addr_err), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   function automatic logic [DATA_W-1:0] pat(int f, int r, int c);
      logic [15:0] w;
      w = 16'(r * 256 + c) ^ 16'(f * 23130);
      return {8{w}};
   endfunction

   task automatic chk(string name, logic [DATA_W-1:0] act, logic [DATA_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      wr_frame_done = 1'b0;
      rd_en = 1'b0;
      rd_frame_done = 1'b0;
      err_clr = 1'b0;
   endtask

   task automatic set_wr(int r, int c, logic [DATA_W-1:0] d);
      wr_en = 1'b1;
      wr_row = IDX_W'(r);
      wr_col = IDX_W'(c);
      wr_data = d;
   endtask

   task automatic set_rd(int r, int c);
      rd_en = 1'b1;
      rd_row = IDX_W'(r);
      rd_col = IDX_W'(c);
   endtask

   always @(negedge clk) begin
      if (rst && rd_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rd_unexpected got rd_valid=1 data %0h expected no read", rd_data);
         end else begin
            chk("rd_data", rd_data, exp_q.pop_front());
         end
      end
   end

   initial begin
      #3;
      chk("rst_wr_ready", wr_ready, 1);
      chk("rst_rd_ready", rd_ready, 0);
      chk("rst_wr_bank", wr_bank, 0);
      chk("rst_rd_bank", rd_bank, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_addr_err", addr_err, 0);
      #9 rst = 1'b1;

      // frame 0 into bank 0
      for (int r = 0; r < 30; r++)
         for (int c = 0; c < 30; c++) begin
            set_wr(r, c, pat(0, r, c));
            tick();
         end
      wr_frame_done = 1'b1;
      tick();
      chk("f0_wr_bank", wr_bank, 1);
      chk("f0_rd_ready", rd_ready, 1);
      chk("f0_wr_ready", wr_ready, 1);
      chk("f0_rd_bank", rd_bank, 0);
      set_rd(5, 7);
      exp_q.push_back(pat(0, 5, 7));
      tick();
      chk("rd57_valid", rd_valid, 1);

      // frame 1 into bank 1 while streaming reads of frame 0
      for (int i = 0; i < 900; i++) begin
         set_wr(i / 30, i % 30, pat(1, i / 30, i % 30));
         set_rd((i * 7) % 30, (i * 11) % 30);
         exp_q.push_back(pat(0, (i * 7) % 30, (i * 11) % 30));
         tick();
      end
      wr_frame_done = 1'b1;
      tick();
      chk("both_full_wr_ready", wr_ready, 0);
      chk("both_full_wr_bank", wr_bank, 0);
      set_wr(0, 0, {8{16'hDEAD}});
      tick();
      wr_frame_done = 1'b1;
      tick();
      chk("stall_wfd_ignored", wr_bank, 0);
      set_rd(0, 0);
      exp_q.push_back(pat(0, 0, 0));
      tick();
      rd_frame_done = 1'b1;
      tick();
      chk("rel_wr_ready", wr_ready, 1);
      chk("rel_wr_bank", wr_bank, 0);
      chk("rel_rd_bank", rd_bank, 1);
      set_rd(0, 0);
      exp_q.push_back(pat(1, 0, 0));
      tick();

      // out-of-range accesses and sticky error
      set_wr(30, 0, {8{16'hBAD0}});
      tick();
      chk("err_wr_row", addr_err, 1);
      set_wr(0, 30, {8{16'hBAD1}});
      tick();
      set_rd(0, 30);
      err_clr = 1'b1;
      tick();
      chk("err_set_over_clr", addr_err, 1);
      chk("err_rd_valid", rd_valid, 0);
      err_clr = 1'b1;
      tick();
      chk("err_cleared", addr_err, 0);
      set_rd(29, 29);
      exp_q.push_back(pat(1, 29, 29));
      tick();
      wr_frame_done = 1'b1;
      tick();
      chk("close0_wr_bank", wr_bank, 1);
      chk("close0_wr_ready", wr_ready, 0);

      // read in the same cycle as releasing the drain bank
      set_rd(2, 2);
      rd_frame_done = 1'b1;
      exp_q.push_back(pat(1, 2, 2));
      tick();
      chk("relrd_valid", rd_valid, 1);
      chk("relrd_rd_bank", rd_bank, 0);
      chk("relrd_wr_ready", wr_ready, 1);
      set_rd(1, 0);
      exp_q.push_back(pat(0, 1, 0));
      tick();

      // simultaneous close and release on different banks
      wr_frame_done = 1'b1;
      rd_frame_done = 1'b1;
      tick();
      chk("sim_wr_bank", wr_bank, 0);
      chk("sim_rd_bank", rd_bank, 1);
      chk("sim_wr_ready", wr_ready, 1);
      chk("sim_rd_ready", rd_ready, 1);
      set_rd(3, 4);
      exp_q.push_back(pat(1, 3, 4));
      tick();

      // async reset mid-frame
      for (int i = 0; i < 100; i++) begin
         set_wr(i / 30, i % 30, pat(2, i / 30, i % 30));
         if (i == 99) set_rd(6, 6);
         tick();
      end
      chk("pre_rst_rd_valid", rd_valid, 1);
      #1 rst = 1'b0;
      #1;
      chk("arst_wr_ready", wr_ready, 1);
      chk("arst_rd_ready", rd_ready, 0);
      chk("arst_wr_bank", wr_bank, 0);
      chk("arst_rd_bank", rd_bank, 0);
      chk("arst_rd_valid", rd_valid, 0);
      #4 rst = 1'b1;
      tick();
      tick();
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/layer_result_pingpong_buf.md
Name: layer_result_pingpong_buf

Overview:
- Parametrised, double-buffered feature-map store between two CNN layers.
- The producer layer writes one full output map by (row, col) into the fill bank, while the consumer layer reads the previously completed map from the drain bank.
- Banks swap under a frame-done handshake on each side.
- Generalises the single-bank, fixed 30x30x128 result memory to arbitrary map size and data width, with ping-pong, read-valid timing and address-range checking.

Parameters:
- DATA_W, 128, bits per map element (all output channels of one pixel packed).
- MAP_W, 30, map columns.
- MAP_H, 30, map rows.
- IDX_W, 16, width of the row/col address ports.
- DEPTH (localparam), MAP_W*MAP_H, entries per bank; AW = $clog2(DEPTH).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- wr_en  in  1  write request.
- wr_row  in  IDX_W  write row.
- wr_col  in  IDX_W  write column.
- wr_data  in  DATA_W  write data.
- wr_frame_done  in  1  producer finished current map; close fill bank.
- wr_ready  out  1  fill bank is free (writes and wr_frame_done accepted).
- rd_en  in  1  read request.
- rd_row  in  IDX_W  read row.
- rd_col  in  IDX_W  read column.
- rd_frame_done  in  1  consumer finished current map; release drain bank.
- rd_ready  out  1  drain bank holds a complete map.
- rd_data  out  DATA_W  read data, valid with rd_valid, else 0.
- rd_valid  out  1  rd_data valid this cycle.
- wr_bank  out  1  index of current fill bank.
- rd_bank  out  1  index of current drain bank.
- addr_err  out  1  sticky out-of-range flag.
- err_clr  in  1  clears addr_err.

Behaviour:
- Reset (rst=0, async): full[1:0]=0, wr_bank=0, rd_bank=0, rd_valid=0, rd_data=0, addr_err=0. Therefore wr_ready=1 and rd_ready=0. Memory contents are not reset.
- Linear address = row*MAP_W + col, computed in AW bits. In range iff row<MAP_H and col<MAP_W, checked on the full IDX_W value before truncation.
- wr_ready = ~full[wr_bank]; rd_ready = full[rd_bank]. Both are combinational from registered flags.
- Write: wr_en & wr_ready & in range -> mem[wr_bank][addr] <= wr_data at the clock edge. wr_en while ~wr_ready -> dropped, no flag change.
- wr_frame_done & wr_ready -> full[wr_bank] <= 1 and wr_bank toggles. A wr_en in the same cycle is written into the bank being closed. wr_frame_done while ~wr_ready is ignored.
- Read, 1-cycle latency: rd_en & rd_ready & in range at edge N -> at edge N+1, rd_valid=1 and rd_data=mem[rd_bank][addr]. Otherwise rd_valid=0 and rd_data=0 on the next cycle. Back-to-back reads give one result per cycle.
- rd_frame_done & rd_ready -> full[rd_bank] <= 0 and rd_bank toggles. A rd_en in the same cycle reads the bank being released, and its data still appears next cycle. rd_frame_done while ~rd_ready is ignored.
- Both banks full -> wr_ready=0 and the producer stalls. Both empty -> rd_ready=0.
- Simultaneous wr_frame_done and rd_frame_done on different banks: both take effect in the same edge.
- A read and a write never target the same bank in the same cycle (fill bank is not full, drain bank is), so no read/write collision exists.
- addr_err is set on any accepted-side request (wr_en & wr_ready, or rd_en & rd_ready) with an out-of-range address. The offending write is not performed and the read returns rd_valid=0.
- addr_err: set has priority over err_clr in the same cycle; otherwise err_clr=1 clears it.
- Reset asserted mid-frame: flags and pointers return to reset values immediately and partial maps are discarded logically.

Test Plan:
- Reset, then write all 900 entries of bank 0 with data = {row,col} replicated, then pulse wr_frame_done -> wr_bank=1, rd_ready=1, wr_ready=1. Read (5,7) -> one cycle later rd_valid=1 and rd_data equals {5,7} pattern.
- Fill bank 1 with a second frame while streaming reads of bank 0 every cycle -> every rd_data matches frame 0; no frame-1 data is visible until after rd_frame_done.
- Fill both banks without any rd_frame_done -> wr_ready=0. A further wr_en to (0,0) does not alter bank 0. rd_frame_done -> wr_ready=1 and wr_bank=0.
- Write to (30,0), then read (0,30) -> addr_err=1, no write, rd_valid=0. Assert err_clr together with a new bad access -> addr_err stays 1. err_clr alone -> addr_err=0.
- In the same cycle, rd_en (2,2) with rd_frame_done -> next cycle rd_valid=1 with the released bank's data, and rd_bank toggled.
- Drive rst low mid-frame after 100 writes -> wr_ready=1, rd_ready=0, wr_bank=rd_bank=0, rd_valid=0 asynchronously, before the next clock edge.
